imem_loader: RTL and testbench

//   Write side of the instruction memory. Receives a byte stream over a valid/ready

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write side of the instruction memory. A byte stream arrives over a
// valid/ready handshake and is packed into little-endian 32-bit words. The
// words are written to consecutive word addresses starting at 0. While a load
// is running, the CPU pipeline is held stalled.
//
// Handshake: a byte moves on a rising edge only when byteValid && byteReady.
// byteReady is high only while the loader is receiving. The source must hold
// byteData stable with byteValid high until it sees byteReady.
//
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous reset, active low
//   start            in   begin a load (looked at only when idle)
//   wordCount        in   number of words to load, captured with start
//   byteValid        in   byteData carries a valid byte
//   byteData         in   incoming byte
//   byteReady        out  loader takes a byte this cycle
//   memWriteEnable   out  one-cycle word write strobe
//   memWriteAddress  out  word address for the write
//   memWriteData     out  assembled word
//   busy             out  load in progress (receiving or writing)
//   cpuStall         out  same as busy; freezes PC/fetch
//   done             out  one-cycle pulse when a load completes
//   dbg_state_o      out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   wordCount,
    input  logic                  byteValid,
    input  logic [7:0]            byteData,
    output logic                  byteReady,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memWriteAddress,
    output logic [31:0]           memWriteData,
    output logic                  busy,
    output logic                  cpuStall,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Memory depth; larger requests are clamped to this.
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_q,      state_d;
    logic [1:0]              byte_idx_q,   byte_idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [ADDR_WIDTH:0]     words_left_q, words_left_d;
    logic [31:0]             word_q,       word_d;

    // Registered outputs, computed from the next state.
    logic ready_q;
    logic we_q;
    logic busy_q;
    logic done_q;

    logic                xfer;
    logic [ADDR_WIDTH:0] count_clamped;

    assign xfer          = byteValid && ready_q;
    assign count_clamped = (wordCount > MAX_WORDS) ? MAX_WORDS : wordCount;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        word_d       = word_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    words_left_d = count_clamped;
                    addr_d       = '0;
                    byte_idx_d   = 2'd0;
                    word_d       = '0;
                    state_d      = (count_clamped == '0) ? ST_DONE : ST_RECV;
                end
            end

            ST_RECV: begin
                if (xfer) begin
                    // Little-endian lane placement: first byte is the LSB.
                    case (byte_idx_q)
                        2'd0:    word_d[7:0]   = byteData;
                        2'd1:    word_d[15:8]  = byteData;
                        2'd2:    word_d[23:16] = byteData;
                        default: word_d[31:24] = byteData;
                    endcase
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = 2'd0;
                        state_d    = ST_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            ST_WRITE: begin
                // addr_q and word_q are stable for this whole cycle and drive
                // the memory port directly; they only advance on leaving.
                if (words_left_q == ONE_WORD) begin
                    state_d = ST_DONE;
                end else begin
                    words_left_d = words_left_q - ONE_WORD;
                    addr_d       = addr_q + 1'b1;
                    state_d      = ST_RECV;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= 2'd0;
            addr_q       <= '0;
            words_left_q <= '0;
            word_q       <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            word_q       <= word_d;
            ready_q      <= (state_d == ST_RECV);
            we_q         <= (state_d == ST_WRITE);
            busy_q       <= (state_d == ST_RECV) || (state_d == ST_WRITE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign byteReady       = ready_q;
    assign memWriteEnable  = we_q;
    assign memWriteAddress = addr_q;
    assign memWriteData    = word_q;
    assign busy            = busy_q;
    assign cpuStall        = busy_q;
    assign done            = done_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   wordCount = '0;
  logic          byteValid = 1'b0;
  logic [7:0]    byteData = '0;
  logic          byteReady;
  logic          memWriteEnable;
  logic [AW-1:0] memWriteAddress;
  logic [31:0]   memWriteData;
  logic          busy;
  logic          cpuStall;
  logic          done;
  logic [1:0]    dbg_state;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .wordCount       (wordCount),
    .byteValid       (byteValid),
    .byteData        (byteData),
    .byteReady       (byteReady),
    .memWriteEnable  (memWriteEnable),
    .memWriteAddress (memWriteAddress),
    .memWriteData    (memWriteData),
    .busy            (busy),
    .cpuStall        (cpuStall),
    .done            (done),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];     // {address, data} of each expected write
  logic [7:0]     stim_q[$];    // byte stream for the current load
  logic [AW+31:0] exp_e;
  int  done_cnt = 0;
  int  exp_done_total = 0;
  bit  exp_we_before_done = 1'b0;
  logic we_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Load of n words consumes the first 4*min(n,DEPTH) bytes of stim_q and
  // writes word i (little-endian) to address i.
  function automatic int clamp_count(input int n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  task automatic push_expected(input int n_eff);
    logic [AW-1:0] a;
    logic [31:0]   w;
    for (int i = 0; i < n_eff; i++) begin
      a = i[AW-1:0];
      w = {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]};
      exp_q.push_back({a, w});
    end
  endtask

  task automatic fill_random(input int nbytes);
    stim_q.delete();
    for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom_range(255, 0)));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("stall_eq_busy", {63'd0, cpuStall}, {63'd0, busy});
      if (memWriteEnable) begin
        check("ready_low_in_write", {63'd0, byteReady}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h required no write",
                   memWriteAddress, memWriteData);
        end else begin
          exp_e = exp_q.pop_front();
          check("write_addr", {54'd0, memWriteAddress}, {54'd0, exp_e[AW+31:32]});
          check("write_data", {32'd0, memWriteData}, {32'd0, exp_e[31:0]});
        end
      end
      if (done) begin
        check("done_busy_low", {63'd0, busy}, 64'd0);
        check("done_after_write", {63'd0, we_prev}, {63'd0, exp_we_before_done});
        check("done_all_written", 64'(exp_q.size()), 64'd0);
        done_cnt++;
      end
      we_prev = memWriteEnable;
    end else begin
      we_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    bit acc;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    byteValid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    byteValid = 1'b1;
    byteData  = b;
    acc = 1'b0;
    for (int t = 0; t < 50; t++) begin
      acc = byteReady;  // registered, so stable until the coming edge
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=no ready required=ready within 50 cycles");
    end
    byteValid = 1'b0;
  endtask

  task automatic run_load(input int n, input int max_gap, input bit poke_start);
    int  n_eff;
    bit  seen;
    n_eff = clamp_count(n);
    push_expected(n_eff);
    exp_we_before_done = (n_eff != 0);
    exp_done_total++;

    start = 1'b1;
    wordCount = n[AW:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (n_eff == 0) begin
      check("zero_done_next_edge", {63'd0, done}, 64'd1);
      check("zero_busy_low", {63'd0, busy}, 64'd0);
    end else begin
      check("busy_after_start", {63'd0, busy}, 64'd1);
      check("ready_after_start", {63'd0, byteReady}, 64'd1);
    end

    for (int i = 0; i < 4 * n_eff; i++) begin
      if (poke_start && i == 5) begin
        start = 1'b1;
        wordCount = 11'd7;
      end
      send_byte(stim_q[i], max_gap);
      start = 1'b0;
    end

    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no done required=done within 20 cycles");
    end

    if (poke_start) begin
      start = 1'b1;  // presented during the done cycle
      wordCount = 11'd9;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("idle_after_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("still_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {63'd0, byteReady}, 64'd0);
    check({tag, "_we"}, {63'd0, memWriteEnable}, 64'd0);
    check({tag, "_addr"}, {54'd0, memWriteAddress}, 64'd0);
    check({tag, "_data"}, {32'd0, memWriteData}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_stall"}, {63'd0, cpuStall}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed two-word program, back-to-back then with gaps.
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 1'b0);
    run_load(2, 3, 1'b0);

    // Empty load.
    run_load(0, 0, 1'b0);

    // Random sizes and gaps.
    repeat (6) begin
      n = $urandom_range(8, 1);
      fill_random(4 * n);
      run_load(n, $urandom_range(3, 0), 1'b0);
    end

    // start pulsed mid-load and during the done cycle.
    fill_random(16);
    run_load(4, 2, 1'b1);

    // Reset after two bytes of the first word.
    fill_random(12);
    push_expected(3);
    start = 1'b1;
    wordCount = 11'd3;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(stim_q[0], 0);
    send_byte(stim_q[1], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset_release");
    fill_random(8);
    run_load(2, 1, 1'b0);

    // Oversized request is clamped to the memory depth.
    fill_random(4 * DEPTH);
    run_load(1100, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_pulse_total", 64'(done_cnt), 64'(exp_done_total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
